rbcp_master: RTL and testbench
==============================

# rbcp_master

Local RBCP initiator that turns single-beat command requests into RBCP bus transactions and returns the outcome. It drives RBCP_ACT/ADDR/WE/WD/RE toward the FPGA register-file responder on the same bus and collects RBCP_RD/RBCP_ACK. It lets on-chip logic, such as init sequencers and self-test, read or write control registers without SiTCP. Every transaction ends in exactly one response: either data or a timeout error.

## Interface
- TIMEOUT, 255: maximum cycles waited for RBCP_ACK after the WE/RE pulse. Legal range 1..65535.
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- CMD_VALID  in  1  command request
- CMD_READY  out  1  block can accept a command; high only in IDLE
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  32  RBCP address
- CMD_WD  in  8  write data; ignored for reads
- RSP_VALID  out  1  one-cycle response strobe
- RSP_RD  out  8  read data; 0 for writes and errors
- RSP_ERR  out  1  timeout flag, qualified by RSP_VALID
- ERR_CNT  out  8  saturating timeout count
- BUSY  out  1  state is not IDLE
- RBCP_ACT  out  1  transaction active
- RBCP_ADDR  out  32  address, held from ISSUE through WAIT
- RBCP_WE  out  1  one-cycle write strobe
- RBCP_WD  out  8  write data, held with RBCP_ADDR
- RBCP_RE  out  1  one-cycle read strobe
- RBCP_RD  in  8  read data, valid with RBCP_ACK
- RBCP_ACK  in  1  one-cycle completion strobe

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE: CMD_READY=1. A command is accepted on a rising edge where CMD_VALID=1. On accept, CMD_ADDR/CMD_WD/CMD_WRITE are latched into the RBCP_ADDR/RBCP_WD/write registers, and the state goes to ISSUE.
- ISSUE (exactly 1 cycle): RBCP_ACT=1, and RBCP_WE=CMD_WRITE or RBCP_RE=!CMD_WRITE. The wait counter is cleared. Next state is WAIT.
- WAIT: RBCP_ACT=1 and WE/RE=0. The counter increments each cycle.
  - RBCP_ACK=1 in WAIT: latch RBCP_RD (read) or 0 (write) into RSP_RD, set RSP_ERR=0, go to DONE.
  - Counter reaches TIMEOUT with no ACK: RSP_RD=0, RSP_ERR=1, ERR_CNT increments and saturates at 255, go to DONE.
  - ACK and timeout in the same cycle: the ACK wins.
- DONE (exactly 1 cycle): RBCP_ACT=0 and RSP_VALID=1. Next state is IDLE.
- RBCP_ACK sampled in IDLE, ISSUE or DONE is ignored. A stray ACK never produces a response.
- RBCP_ADDR/RBCP_WD hold their last value after the transaction. They change only on accept.
- Reset mid-transaction: RBCP_ACT/WE/RE and RSP_VALID drop immediately (asynchronous). No response is issued. The state returns to IDLE.

## Timing
- Reset values: CMD_READY=1 (IDLE); RSP_VALID, RSP_ERR, BUSY, RBCP_ACT, RBCP_WE, RBCP_RE = 0; RSP_RD, ERR_CNT, RBCP_ADDR, RBCP_WD = 0. No command is accepted while RST=1.
- Accept at edge t0: ISSUE occupies cycle t0..t1, with the WE/RE pulse and ACT rising visible after t0.
- ACK sampled at edge tA: RSP_VALID=1 for the cycle following tA, and ACT falls in that same cycle.
- Total latency, accept to RSP_VALID = responder ACK delay (in cycles after the pulse) + 2.
- Timeout: the TIMEOUT-th WAIT cycle without ACK is followed by RSP_VALID=1 with RSP_ERR=1.
- Back-to-back: the earliest next accept is the edge ending DONE's following IDLE cycle. RBCP_ACT is low for at least 2 cycles between transactions.
- All outputs are registered. No combinational path runs from RBCP_ACK/RD to any output.

## Configuration
- RBCP_MASTER_TIMEOUT_EN defined: the timeout counter, the error path and ERR_CNT are implemented as described above.
- RBCP_MASTER_TIMEOUT_EN undefined: WAIT persists until RBCP_ACK with no upper bound. RSP_ERR and ERR_CNT are tied 0. TIMEOUT is ignored and the counter is not synthesized.

## Test plan
Responder model: register-file behaviour, ACK 4 cycles after the WE/RE pulse, no ACK for addresses ≥ 0x100. TIMEOUT=16 unless noted.
- Write addr 0x08, data 0x5A -> one WE pulse, ACT high 5 cycles, RSP_VALID 6 cycles after accept, RSP_ERR=0, RSP_RD=0x00.
- Read 0x08 after the write above -> RSP_RD=0x5A. Read 0x00 -> 0xEA. Read 0x04 -> 0x17.
- Read 0x100 -> no ACK, RSP_VALID with RSP_ERR=1 and RSP_RD=0 after 16 WAIT cycles, ERR_CNT=1. Repeat 300 times -> ERR_CNT=255.
- Responder with ACK delay exactly 16 -> ACK wins, RSP_ERR=0, ERR_CNT unchanged.
- CMD_VALID held high for 3 queued commands -> 3 transactions, RBCP_ACT low ≥2 cycles between them, 3 responses in order. A stray ACK injected in IDLE -> no extra RSP_VALID.
- Assert RST 2 cycles into WAIT -> ACT/RE drop immediately, no RSP_VALID. After release, a read of 0x09 returns 0x09.

Source files
------------

// File: rtl/rbcp_master.sv
`default_nettype none
// ============================================================================
// Module   : rbcp_master
// Purpose  : Local RBCP initiator. Turns single-beat command requests into
//            one RBCP bus transaction (ISSUE pulse, WAIT for ACK) and returns
//            exactly one response per accepted command: read data or a
//            timeout error.
// Options  : RBCP_MASTER_TIMEOUT_EN - when defined, WAIT is bounded by
//            TIMEOUT cycles and timeouts are reported on RSP_ERR / ERR_CNT.
//            When undefined, WAIT lasts until RBCP_ACK, RSP_ERR and ERR_CNT
//            are tied low and no wait counter exists.
// Revision : 1.0 - initial release
// ============================================================================
module rbcp_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    // command side
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [7:0]  CMD_WD,
    // response side
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RD,
    output logic        RSP_ERR,
    output logic [7:0]  ERR_CNT,
    output logic        BUSY,
    // RBCP bus toward the register-file responder
    output logic        RBCP_ACT,
    output logic [31:0] RBCP_ADDR,
    output logic        RBCP_WE,
    output logic [7:0]  RBCP_WD,
    output logic        RBCP_RE,
    input  logic [7:0]  RBCP_RD,
    input  logic        RBCP_ACK
);

    // ------------------------------------------------------------------------
    // Elaboration-time guard: the wait counter is 16 bits wide, so TIMEOUT
    // must fit in 1..65535.
    // ------------------------------------------------------------------------
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_timeout_range_check
        $error("rbcp_master: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e      state_q;

    // Registered outputs; every port is driven straight from a flop so that
    // nothing on RBCP_ACK/RBCP_RD reaches an output combinationally.
    logic        ready_q;
    logic        busy_q;
    logic        act_q;
    logic        we_q;
    logic        re_q;
    logic [31:0] addr_q;
    logic [7:0]  wd_q;
    logic        write_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rd_q;

`ifdef RBCP_MASTER_TIMEOUT_EN
    // wait_cnt_q holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt_q;
    logic        rsp_err_q;
    logic [7:0]  err_cnt_q;
`endif

    // Transaction sequencer: IDLE -> ISSUE -> WAIT -> DONE -> IDLE, with all
    // bus and response outputs updated alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            act_q       <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wd_q        <= 8'h00;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 8'h00;
`ifdef RBCP_MASTER_TIMEOUT_EN
            wait_cnt_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= 8'h00;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Accept: latch the command and raise ACT plus the
                    // one-cycle WE or RE pulse for the ISSUE cycle.
                    if (CMD_VALID) begin
                        addr_q  <= CMD_ADDR;
                        wd_q    <= CMD_WD;
                        write_q <= CMD_WRITE;
                        we_q    <= CMD_WRITE;
                        re_q    <= ~CMD_WRITE;
                        act_q   <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // The strobe is a single cycle; ACT stays up through WAIT.
                    // An ACK seen here is ignored.
                    we_q    <= 1'b0;
                    re_q    <= 1'b0;
`ifdef RBCP_MASTER_TIMEOUT_EN
                    wait_cnt_q <= 16'h0000;
`endif
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // ACK is checked first so that it wins over a timeout
                    // landing in the same cycle.
                    if (RBCP_ACK) begin
                        rsp_rd_q    <= write_q ? 8'h00 : RBCP_RD;
`ifdef RBCP_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        act_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`ifdef RBCP_MASTER_TIMEOUT_EN
                    else if (wait_cnt_q == TIMEOUT_LAST) begin
                        rsp_rd_q    <= 8'h00;
                        rsp_err_q   <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        act_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
`endif
                end

                ST_DONE: begin
                    // Response strobe lasts one cycle; ACT already low, and
                    // the following IDLE cycle gives the second low cycle.
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    act_q       <= 1'b0;
                    we_q        <= 1'b0;
                    re_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign CMD_READY = ready_q;
    assign BUSY      = busy_q;
    assign RBCP_ACT  = act_q;
    assign RBCP_WE   = we_q;
    assign RBCP_RE   = re_q;
    assign RBCP_ADDR = addr_q;
    assign RBCP_WD   = wd_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RD    = rsp_rd_q;

`ifdef RBCP_MASTER_TIMEOUT_EN
    assign RSP_ERR   = rsp_err_q;
    assign ERR_CNT   = err_cnt_q;
`else
    assign RSP_ERR   = 1'b0;
    assign ERR_CNT   = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rbcp_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbcp_master
// Purpose  : Self-checking bench for rbcp_master. A register-file responder
//            acknowledges a configurable number of cycles after each strobe
//            and never answers addresses >= 0x100. Expected responses come
//            from a transaction-level model of the command/timeout rules.
// Options  : follows RBCP_MASTER_TIMEOUT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rbcp_master;

    localparam int TIMEOUT   = 16;
    localparam int RSP_LIMIT = TIMEOUT + 40;
`ifdef RBCP_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic        CMD_WRITE = 1'b0;
    logic [31:0] CMD_ADDR = 32'h0;
    logic [7:0]  CMD_WD = 8'h0;
    logic        RSP_VALID;
    logic [7:0]  RSP_RD;
    logic        RSP_ERR;
    logic [7:0]  ERR_CNT;
    logic        BUSY;
    logic        RBCP_ACT;
    logic [31:0] RBCP_ADDR;
    logic        RBCP_WE;
    logic [7:0]  RBCP_WD;
    logic        RBCP_RE;
    logic [7:0]  RBCP_RD = 8'h00;
    logic        RBCP_ACK = 1'b0;

    rbcp_master #(.TIMEOUT(TIMEOUT)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WRITE (CMD_WRITE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WD    (CMD_WD),
        .RSP_VALID (RSP_VALID),
        .RSP_RD    (RSP_RD),
        .RSP_ERR   (RSP_ERR),
        .ERR_CNT   (ERR_CNT),
        .BUSY      (BUSY),
        .RBCP_ACT  (RBCP_ACT),
        .RBCP_ADDR (RBCP_ADDR),
        .RBCP_WE   (RBCP_WE),
        .RBCP_WD   (RBCP_WD),
        .RBCP_RE   (RBCP_RE),
        .RBCP_RD   (RBCP_RD),
        .RBCP_ACK  (RBCP_ACK)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Responder: register file, ACK during the resp_delay-th cycle after the
    // strobe, silent for addresses >= 0x100. Stray ACKs on request.
    // ------------------------------------------------------------------------
    logic [7:0] rsp_mem [256];
    int         resp_delay = 4;
    int         cd = 0;
    logic [7:0] pend_rd = 8'h00;
    bit         stray_req = 1'b0;

    always @(negedge CLK) begin
        RBCP_ACK = 1'b0;
        if (RST) begin
            cd = 0;
        end else begin
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    RBCP_ACK = 1'b1;
                    RBCP_RD  = pend_rd;
                end
            end
            if (RBCP_WE || RBCP_RE) begin
                cd = 0;
                if (RBCP_ADDR < 32'h100) begin
                    cd = resp_delay;
                    if (RBCP_WE) begin
                        rsp_mem[RBCP_ADDR[7:0]] = RBCP_WD;
                        pend_rd = 8'hFF;
                    end else begin
                        pend_rd = rsp_mem[RBCP_ADDR[7:0]];
                    end
                end
            end
            if (stray_req) begin
                RBCP_ACK  = 1'b1;
                RBCP_RD   = 8'hCC;
                stray_req = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: response log and ACT low-gap tracking
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] rd;
        logic       err;
    } rsp_t;

    rsp_t rsp_q[$];
    int   vcnt = 0;
    int   low_run = 0;
    int   gap_viol = 0;
    bit   seen_act = 1'b0;
    bit   prev_act = 1'b0;

    always @(negedge CLK) begin
        rsp_t r;
        if (RSP_VALID) begin
            vcnt++;
            r.rd  = RSP_RD;
            r.err = RSP_ERR;
            rsp_q.push_back(r);
        end
        if (RBCP_ACT && !prev_act) begin
            if (seen_act && low_run < 2) gap_viol++;
            seen_act = 1'b1;
        end
        if (RBCP_ACT) low_run = 0;
        else          low_run++;
        prev_act = RBCP_ACT;
    end

    // ------------------------------------------------------------------------
    // Reference model: what one command must produce, from the responder's
    // behaviour and the ACK-versus-timeout rule.
    // ------------------------------------------------------------------------
    logic [7:0] ref_mem [256];
    int         ref_errcnt = 0;

    function automatic void model_txn(input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                                      input int delay, output bit valid, output logic [7:0] rd,
                                      output bit err, output int lat);
        bit acked;
        acked = (addr < 32'h100);
        valid = 1'b0;
        rd    = 8'h00;
        err   = 1'b0;
        lat   = 0;
        if (acked && (!TO_EN || delay <= TIMEOUT)) begin
            valid = 1'b1;
            lat   = delay + 2;
            rd    = wr ? 8'h00 : ref_mem[addr[7:0]];
        end else if (TO_EN) begin
            valid = 1'b1;
            err   = 1'b1;
            lat   = TIMEOUT + 2;
            if (ref_errcnt < 255) ref_errcnt++;
        end
        if (acked && wr) ref_mem[addr[7:0]] = wd;
    endfunction

    task automatic reset_dut();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        ref_errcnt = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < RSP_LIMIT) begin
            @(negedge CLK);
            n++;
        end
    endtask

    // One complete command with full outcome checking.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [7:0] wd, input int delay);
        bit         e_valid;
        logic [7:0] e_rd;
        bit         e_err;
        int         e_lat;
        int         lat = -1;
        int         act_hi = 0;
        int         we_n = 0;
        int         re_n = 0;
        int         v0;
        model_txn(wr, addr, wd, delay, e_valid, e_rd, e_err, e_lat);
        resp_delay = delay;
        wait_ready();
        v0 = vcnt;
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_WD    = wd;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        for (int i = 1; i <= RSP_LIMIT; i++) begin
            @(negedge CLK);
            if (RBCP_ACT) act_hi++;
            if (RBCP_WE)  we_n++;
            if (RBCP_RE)  re_n++;
            if (RSP_VALID) begin
                lat = i;
                break;
            end
        end
        if (e_valid) begin
            chk("latency",   lat,       e_lat);
            chk("rsp_rd",    RSP_RD,    e_rd);
            chk("rsp_err",   RSP_ERR,   e_err);
            chk("err_cnt",   ERR_CNT,   ref_errcnt);
            chk("act_high",  act_hi,    e_lat - 1);
            chk("we_pulses", we_n,      wr);
            chk("re_pulses", re_n,      !wr);
            chk("addr_hold", RBCP_ADDR, addr);
            chk("wd_hold",   RBCP_WD,   wd);
            @(negedge CLK);
            chk("valid_1cyc", RSP_VALID, 1'b0);
            chk("ready_idle", CMD_READY, 1'b1);
            chk("addr_after", RBCP_ADDR, addr);
        end else begin
            chk("no_response", vcnt - v0, 0);
            chk("stuck_wait",  RBCP_ACT,  1'b1);
            reset_dut();
        end
    endtask

    // Three commands with CMD_VALID held high throughout.
    task automatic queued3();
        bit         qw [3];
        logic [31:0] qa [3];
        logic [7:0] qd [3];
        bit         ev [3];
        logic [7:0] er [3];
        bit         ee [3];
        int         el [3];
        int         k = 0;
        int         n = 0;
        qw[0] = 1'b1; qa[0] = 32'h20; qd[0] = 8'h3C;
        qw[1] = 1'b0; qa[1] = 32'h20; qd[1] = 8'h11;
        qw[2] = 1'b0; qa[2] = 32'h04; qd[2] = 8'h22;
        for (int i = 0; i < 3; i++) model_txn(qw[i], qa[i], qd[i], 4, ev[i], er[i], ee[i], el[i]);
        resp_delay = 4;
        wait_ready();
        rsp_q.delete();
        gap_viol = 0;
        CMD_VALID = 1'b1;
        CMD_WRITE = qw[0]; CMD_ADDR = qa[0]; CMD_WD = qd[0];
        while (k < 3 && n < 200) begin
            if (CMD_READY) begin
                @(posedge CLK);
                #1;
                k++;
                if (k < 3) begin
                    CMD_WRITE = qw[k]; CMD_ADDR = qa[k]; CMD_WD = qd[k];
                end else begin
                    CMD_VALID = 1'b0;
                end
            end
            @(negedge CLK);
            n++;
        end
        CMD_VALID = 1'b0;
        n = 0;
        while (rsp_q.size() < 3 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        chk("q_count", rsp_q.size(), 3);
        for (int i = 0; i < 3 && i < rsp_q.size(); i++) begin
            chk("q_rd",  rsp_q[i].rd,  er[i]);
            chk("q_err", rsp_q[i].err, ee[i]);
        end
        chk("q_act_gap", gap_viol, 0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int v0;
        for (int i = 0; i < 256; i++) begin
            rsp_mem[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        rsp_mem[0] = 8'hEA; ref_mem[0] = 8'hEA;
        rsp_mem[4] = 8'h17; ref_mem[4] = 8'h17;

        // Reset values, and no accept while reset is held
        repeat (2) @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_ADDR  = 32'h08;
        repeat (2) @(negedge CLK);
        chk("rst_ready",   CMD_READY, 1'b1);
        chk("rst_valid",   RSP_VALID, 1'b0);
        chk("rst_err",     RSP_ERR,   1'b0);
        chk("rst_busy",    BUSY,      1'b0);
        chk("rst_act",     RBCP_ACT,  1'b0);
        chk("rst_we",      RBCP_WE,   1'b0);
        chk("rst_re",      RBCP_RE,   1'b0);
        chk("rst_rd",      RSP_RD,    8'h00);
        chk("rst_errcnt",  ERR_CNT,   8'h00);
        chk("rst_addr",    RBCP_ADDR, 32'h0);
        chk("rst_wd",      RBCP_WD,   8'h00);
        CMD_VALID = 1'b0;
        RST = 1'b0;

        // Directed register-file traffic
        do_txn(1'b1, 32'h08, 8'h5A, 4);
        do_txn(1'b0, 32'h08, 8'h00, 4);
        do_txn(1'b0, 32'h00, 8'h00, 4);
        do_txn(1'b0, 32'h04, 8'h00, 4);

        // Unanswered address
`ifdef RBCP_MASTER_TIMEOUT_EN
        do_txn(1'b0, 32'h100, 8'h00, 4);
        chk("errcnt_first", ERR_CNT, 8'd1);
        for (int i = 0; i < 299; i++) do_txn(1'b0, 32'h100 + i, 8'h00, 4);
        chk("errcnt_sat", ERR_CNT, 8'd255);
`else
        do_txn(1'b0, 32'h100, 8'h00, 4);
`endif

        // ACK landing on the last allowed WAIT cycle
        do_txn(1'b0, 32'h08, 8'h00, TIMEOUT);

        // Back-to-back queued commands, then a stray ACK while idle
        queued3();
        wait_ready();
        v0 = vcnt;
        stray_req = 1'b1;
        repeat (6) @(negedge CLK);
        chk("stray_ack", vcnt - v0, 0);

        // Reset two cycles into WAIT
        resp_delay = 10;
        wait_ready();
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h08; CMD_WD = 8'h00;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        v0 = vcnt;
        repeat (3) @(negedge CLK);
        chk("pre_rst_act", RBCP_ACT, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("arst_act",   RBCP_ACT,  1'b0);
        chk("arst_re",    RBCP_RE,   1'b0);
        chk("arst_valid", RSP_VALID, 1'b0);
        chk("arst_busy",  BUSY,      1'b0);
        chk("arst_ready", CMD_READY, 1'b1);
        ref_errcnt = 0;
        CMD_VALID = 1'b1; CMD_ADDR = 32'h09;
        repeat (2) @(negedge CLK);
        chk("arst_no_accept", RBCP_ACT, 1'b0);
        CMD_VALID = 1'b0;
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        chk("arst_no_rsp", vcnt - v0, 0);
        chk("arst_errcnt", ERR_CNT, 8'h00);
        do_txn(1'b0, 32'h09, 8'h00, 4);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit          wr;
            logic [31:0] addr;
            logic [7:0]  wd;
            int          dly;
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 32'h100 + $urandom_range(0, 255) : 32'($urandom_range(0, 31));
            wd   = 8'($urandom);
            dly  = $urandom_range(1, TIMEOUT + 2);
            do_txn(wr, addr, wd, dly);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
